tone_sample_gen: RTL and testbench
==================================

Name: tone_sample_gen

Overview:
- Per-note square-wave sample source placed directly upstream of Audio_Controller.
- Accepts one note at a time from the song sequencer via a valid/ready handshake. A note is a half-period in clocks plus a duration in clocks.
- Produces signed 32-bit left/right samples and the write strobe for Audio_Controller's DAC FIFO.
- Inserts a silent articulation gap after every note so that repeated notes stay distinct.

Parameters:
- AMPLITUDE, 100000000, peak sample magnitude; output swings between +AMPLITUDE and -AMPLITUDE.
- HP_W, 19, width of note_half_period.
- DUR_W, 23, width of note_duration.
- GAP_CYCLES, 250000, silent clocks after each note (5 ms at 50 MHz); must be >= 1.
- ENV_SHIFT_CYCLES, 1250000, clocks per envelope step (used only with ENVELOPE_EN).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- note_valid  in  1  sequencer presents a note
- note_ready  out  1  block can accept a note this cycle
- note_half_period  in  HP_W  clocks per half-cycle minus 1; 0 means rest (silence)
- note_duration  in  DUR_W  note length in clocks; 0 is treated as 1
- audio_out_allowed  in  1  Audio_Controller DAC FIFO has space
- write_audio_out  out  1  sample write strobe
- left_channel_audio_out  out  32  signed sample
- right_channel_audio_out  out  32  identical to left
- note_done  out  1  one-cycle pulse when a note's gap ends
- busy  out  1  high in PLAY or GAP

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is asynchronous, active-low on resetn.
- Reset values:
  - state = IDLE.
  - All counters = 0.
  - phase = 0.
  - Sample registers = 0.
  - note_ready = 1, write_audio_out = 0, note_done = 0, busy = 0.
- State IDLE:
  - note_ready = 1.
  - On note_valid & note_ready, in the same edge:
    - latch half-period into hp_reg;
    - latch max(duration, 1) into dur_cnt;
    - clear hp_cnt, set phase = 0, go to PLAY.
- State PLAY:
  - note_ready = 0.
  - dur_cnt decrements every cycle. When dur_cnt == 1: load gap_cnt = GAP_CYCLES and go to GAP.
  - Square wave:
    - if hp_cnt == hp_reg then hp_cnt <= 0 and phase toggles;
    - otherwise hp_cnt increments.
    - Full period = 2*(hp_reg+1) clocks.
  - Sample register:
    - hp_reg == 0 (rest): 0;
    - phase = 0: +amp;
    - phase = 1: -amp (two's complement).
    - amp = AMPLITUDE.
  - Sample latency: sample registers update one clock after the phase change.
- State GAP:
  - Sample register is forced to 0 from the first GAP cycle.
  - gap_cnt decrements. When gap_cnt == 1: pulse note_done for one cycle and return to IDLE.
  - A note presented in that same cycle is not accepted; the earliest acceptance is the next cycle.
- Output strobe:
  - write_audio_out = audio_out_allowed, combinational, in every state including IDLE (IDLE writes 0 samples).
  - This keeps the DAC FIFO fed. Samples are held registers, valid whenever the strobe is high.
- Backpressure: when audio_out_allowed is low, timing counters keep running; the sample stream is rate-decoupled, not stalled.
- note_valid is ignored in PLAY and GAP; the sequencer must hold its note until note_ready.
- Reset mid-note: outputs go to zero immediately (asynchronous), the note is discarded, and the block returns to IDLE.
- Arithmetic: all counters are unsigned with no wrap-around, because the terminal compare always precedes the wrap. The sample is a sign-extended 32-bit value.

Optional Feature:
- Macro: TONE_SAMPLE_GEN_ENVELOPE_EN.
- Defined:
  - amp starts at AMPLITUDE on note accept.
  - Every ENV_SHIFT_CYCLES clocks in PLAY, amp shifts right by 1.
  - The shift saturates after 4 steps, i.e. at AMPLITUDE>>4.
  - The envelope counter resets on each accept.
- Undefined:
  - amp is constant AMPLITUDE.
  - The envelope counter and shift logic are absent.

Test Plan:
1. Reset held then released, audio_out_allowed=1, no notes -> note_ready=1, busy=0, write_audio_out=1, samples=0 indefinitely.
2. Note hp=4, dur=40 with GAP_CYCLES=8 -> samples +100000000 for 5 clocks, then -100000000 for 5, repeated 4 periods. Then 8 clocks of 0, note_done pulse, note_ready=1 exactly 48 clocks after accept.
3. Note hp=0, dur=10 (rest), GAP_CYCLES=8 -> samples 0 throughout, busy high 18 clocks, single note_done pulse.
4. Second note held valid during PLAY/GAP of first -> not accepted until the cycle after note_done. dur=0 is accepted and behaves as 1 PLAY cycle.
5. resetn asserted mid-PLAY, then released -> outputs 0 and note_ready=1 immediately. A new note then plays from phase 0 with correct period.
6. ENVELOPE_EN with ENV_SHIFT_CYCLES=10, hp=99, dur=100 -> amplitude steps 100000000, 50000000, 25000000, 12500000, 6250000, then holds 6250000 until GAP.

Source files
------------

// File: rtl/tone_sample_gen.sv
// tone_sample_gen
//
// Square-wave sample source that sits directly upstream of Audio_Controller.
// It takes one note at a time from the song sequencer over a valid/ready
// handshake. A note is a half-period in clocks minus one (0 means a rest)
// and a duration in clocks (0 is treated as 1). While the note plays, the
// block produces a signed 32-bit square wave. After every note it inserts a
// silent gap of GAP_CYCLES clocks so that repeated notes stay distinct.
//
// Optional feature: define TONE_SAMPLE_GEN_ENVELOPE_EN to add a decaying
// envelope. The amplitude halves every ENV_SHIFT_CYCLES clocks of PLAY and
// stops decaying at AMPLITUDE>>4. Without the macro the amplitude is the
// constant AMPLITUDE, and the envelope logic and its parameter do not exist.
//
// Ports:
//   CLOCK_50                 in   system clock (50 MHz)
//   resetn                   in   asynchronous active-low reset
//   note_valid               in   sequencer presents a note
//   note_ready               out  a note can be accepted this cycle (IDLE)
//   note_half_period [HP_W]  in   clocks per half-cycle minus 1; 0 = rest
//   note_duration   [DUR_W]  in   note length in clocks; 0 treated as 1
//   audio_out_allowed        in   DAC FIFO has space
//   write_audio_out          out  sample write strobe (= audio_out_allowed)
//   left_channel_audio_out   out  signed 32-bit sample
//   right_channel_audio_out  out  same value as left
//   note_done                out  one-cycle pulse in the last gap cycle
//   busy                     out  high while in PLAY or GAP

module tone_sample_gen #(
  parameter int          AMPLITUDE  = 100000000,
  parameter int unsigned HP_W       = 19,
  parameter int unsigned DUR_W      = 23,
  parameter int unsigned GAP_CYCLES = 250000
`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
  ,
  parameter int unsigned ENV_SHIFT_CYCLES = 1250000
`endif
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [HP_W-1:0]   note_half_period,
  input  logic [DUR_W-1:0]  note_duration,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              note_done,
  output logic              busy
);

  // The counter is at least 2 bits wide so that the "one before last" compare
  // used for the registered note_done stays meaningful when GAP_CYCLES is 1.
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

  localparam logic signed [31:0] AmpFull = 32'(AMPLITUDE);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_e;

  state_e             state;
  logic [HP_W-1:0]    hp_reg;
  logic [HP_W-1:0]    hp_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               phase;
  logic signed [31:0] sample;

  logic signed [31:0] amp;
  logic signed [31:0] play_sample;

`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
  localparam int unsigned ENV_W = $clog2(ENV_SHIFT_CYCLES + 1);
  localparam logic [2:0]  EnvStepMax = 3'd4;

  logic [ENV_W-1:0] env_cnt;
  logic [2:0]       env_step;

  always_comb begin
    amp = AmpFull >>> env_step;
  end
`else
  always_comb begin
    amp = AmpFull;
  end
`endif

  // Value to register during a PLAY cycle; a rest (hp_reg == 0) stays silent.
  always_comb begin
    play_sample = '0;
    if (hp_reg != '0) begin
      play_sample = phase ? -amp : amp;
    end
  end

  // Main FSM. note_ready, busy and note_done are registered and are updated
  // so that they describe the state entered at the same edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      hp_reg     <= '0;
      hp_cnt     <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      phase      <= 1'b0;
      sample     <= '0;
      note_ready <= 1'b1;
      note_done  <= 1'b0;
      busy       <= 1'b0;
`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
      env_cnt    <= '0;
      env_step   <= '0;
`endif
    end else begin
      note_done <= 1'b0;
      case (state)
        StIdle: begin
          sample <= '0;
          if (note_valid && note_ready) begin
            hp_reg     <= note_half_period;
            dur_cnt    <= (note_duration == '0) ? DUR_W'(1) : note_duration;
            hp_cnt     <= '0;
            phase      <= 1'b0;
            state      <= StPlay;
            note_ready <= 1'b0;
            busy       <= 1'b1;
`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
            env_cnt    <= '0;
            env_step   <= '0;
`endif
          end
        end

        StPlay: begin
          // Sample follows the phase register, so it lags a phase flip by a clock.
          sample <= play_sample;

          if (hp_cnt == hp_reg) begin
            hp_cnt <= '0;
            phase  <= ~phase;
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end

`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
          if (env_cnt == ENV_W'(ENV_SHIFT_CYCLES - 1)) begin
            env_cnt <= '0;
            if (env_step != EnvStepMax) begin
              env_step <= env_step + 3'd1;
            end
          end else begin
            env_cnt <= env_cnt + ENV_W'(1);
          end
`endif

          dur_cnt <= dur_cnt - DUR_W'(1);
          if (dur_cnt == DUR_W'(1)) begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= StGap;
            // A single-cycle gap means the next cycle is already the last one.
            if (GAP_CYCLES == 1) begin
              note_done <= 1'b1;
            end
          end
        end

        StGap: begin
          sample  <= '0;
          gap_cnt <= gap_cnt - GAP_W'(1);
          // Raise note_done so that it is visible during the gap_cnt == 1 cycle.
          if (gap_cnt == GAP_W'(2)) begin
            note_done <= 1'b1;
          end
          if (gap_cnt == GAP_W'(1)) begin
            state      <= StIdle;
            note_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: begin
          state      <= StIdle;
          sample     <= '0;
          note_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // The FIFO is fed on every cycle it has room. The samples are held
  // registers, so the current value is always the one to write.
  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_tone_sample_gen.sv
// Testbench for tone_sample_gen. The reference model describes each note in
// terms of the cycle at which it was accepted: busy window, done cycle and the
// square-wave value expected at each later cycle.
module tb_tone_sample_gen;

  localparam int AMP  = 100000000;
  localparam int HPW  = 19;
  localparam int DURW = 23;
  localparam int GAP  = 8;
  localparam int ENV  = 10;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            note_valid = 1'b0;
  logic            note_ready;
  logic [HPW-1:0]  hp_in = '0;
  logic [DURW-1:0] dur_in = '0;
  logic            allowed = 1'b0;
  logic            write_audio_out;
  logic [31:0]     left_out;
  logic [31:0]     right_out;
  logic            note_done;
  logic            busy;

  tone_sample_gen #(
    .AMPLITUDE        (AMP),
    .HP_W             (HPW),
    .DUR_W            (DURW),
    .GAP_CYCLES       (GAP)
`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
    ,
    .ENV_SHIFT_CYCLES (ENV)
`endif
  ) dut (
    .CLOCK_50                (clk),
    .resetn                  (resetn),
    .note_valid              (note_valid),
    .note_ready              (note_ready),
    .note_half_period        (hp_in),
    .note_duration           (dur_in),
    .audio_out_allowed       (allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .note_done               (note_done),
    .busy                    (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the last accepted note and the cycle in which it was accepted.
  longint cyc = 0;
  longint acc_cyc = 0;
  bit     have_note = 1'b0;
  int     m_hp = 0;
  int     m_d = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected sample t cycles after acceptance: the wave of PLAY cycle k shows
  // up one cycle later, and everything outside the note is silent.
  function automatic int exp_sample(input longint t);
    longint k;
    int     a;
    int     step;
    if (!have_note || t < 2 || t > m_d + 1) return 0;
    if (m_hp == 0) return 0;
    k = t - 1;
    step = 0;
`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
    step = int'((k - 1) / ENV);
    if (step > 4) step = 4;
`endif
    a = AMP >> step;
    return (((k - 1) / (m_hp + 1)) % 2 == 1) ? -a : a;
  endfunction

  // One clock: drive inputs, check outputs of the current cycle, and advance.
  task automatic step(input bit v, input int hp, input int dur, input bit al,
                      output bit accepted);
    longint t;
    bit     busy_e;
    bit     done_e;
    int     s_e;
    @(negedge clk);
    resetn     = 1'b1;
    note_valid = v;
    hp_in      = HPW'(hp);
    dur_in     = DURW'(dur);
    allowed    = al;
    #1;
    t      = cyc - acc_cyc;
    busy_e = have_note && t >= 1 && t <= m_d + GAP;
    done_e = have_note && t == m_d + GAP;
    s_e    = exp_sample(t);
    check_eq("busy", busy, busy_e);
    check_eq("note_ready", note_ready, !busy_e);
    check_eq("note_done", note_done, done_e);
    check_eq("left", left_out, s_e);
    check_eq("right", right_out, s_e);
    check_eq("write_audio_out", write_audio_out, al);
    accepted = v && !busy_e;
    @(posedge clk);
    if (accepted) begin
      have_note = 1'b1;
      acc_cyc   = cyc;
      m_hp      = hp;
      m_d       = (dur == 0) ? 1 : dur;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, a);
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    resetn     = 1'b0;
    note_valid = 1'b0;
    #1;
    check_eq("rst_left", left_out, 0);
    check_eq("rst_right", right_out, 0);
    check_eq("rst_ready", note_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", note_done, 0);
    have_note = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    bit acc;
    bit pend;
    int php;
    int pdur;

    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", note_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_left", left_out, 0);
    check_eq("reset_done", note_done, 0);

    // Idle after reset: silent samples, strobe follows audio_out_allowed.
    idle(10);

    // Tone hp=4, dur=40.
    step(1'b1, 4, 40, 1'b1, acc);
    check_eq("accept_tone", acc, 1);
    idle(55);

    // Rest hp=0, dur=10.
    step(1'b1, 0, 10, 1'b1, acc);
    idle(25);

    // Second note held during the first; dur=0 plays one cycle.
    step(1'b1, 3, 12, 1'b1, acc);
    for (int i = 0; i < 30; i++) step(1'b1, 2, 0, 1'b1, acc);
    idle(15);

    // Reset mid-PLAY, then a fresh note from phase 0.
    step(1'b1, 5, 50, 1'b1, acc);
    idle(15);
    mid_reset();
    step(1'b1, 5, 30, 1'b1, acc);
    idle(45);

`ifdef TONE_SAMPLE_GEN_ENVELOPE_EN
    step(1'b1, 99, 100, 1'b1, acc);
    idle(115);
`endif

    // Randomized traffic with backpressure and occasional resets.
    pend = 1'b0;
    php  = 0;
    pdur = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        php  = int'($urandom_range(0, 6));
        pdur = int'($urandom_range(0, 25));
      end
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        step(pend, php, pdur, 1'($urandom_range(0, 1)), acc);
        if (acc) pend = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
